// File: rtl/seq_div32.sv
// Iterative unsigned WIDTH/WIDTH restoring divider, one quotient bit per clock.
// The trial subtraction is done by an external shared (WIDTH+1)-bit add/sub unit.
module seq_div32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] as_a,
    output logic [WIDTH-1:0] as_b,
    output logic             as_c0,
    input  logic [WIDTH:0]   as_s
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] d;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] r_next;
    logic [WIDTH-1:0] q_next;
    logic             ok;

    // R[W-1] set means the shifted value needs W+1 bits, so it already exceeds D.
    always_comb begin
        shifted = {r[WIDTH-2:0], q[WIDTH-1]};
        ok      = r[WIDTH-1] | ~as_s[WIDTH];
        r_next  = ok ? as_s[WIDTH-1:0] : shifted;
        q_next  = {q[WIDTH-2:0], ok};
        as_a    = '0;
        as_b    = '0;
        as_c0   = 1'b0;
        if (state == RUN) begin
            as_a  = shifted;
            as_b  = d;
            as_c0 = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            r           <= '0;
            q           <= '0;
            d           <= '0;
            cnt         <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        r     <= '0;
                        q     <= dividend;
                        d     <= divisor;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    r   <= r_next;
                    q   <= q_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        quotient    <= q_next;
                        remainder   <= r_next;
                        div_by_zero <= (d == '0);
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        state       <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_div32.sv
// Directed and randomised bench for seq_div32 with a behavioural add/sub unit
// and a division golden model.
module tb_seq_div32;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [W-1:0]   dividend = '0;
    logic [W-1:0]   divisor = '0;
    logic           busy;
    logic           done;
    logic [W-1:0]   quotient;
    logic [W-1:0]   remainder;
    logic           div_by_zero;
    logic [W-1:0]   as_a;
    logic [W-1:0]   as_b;
    logic           as_c0;
    logic [W:0]     as_s;

    int checks = 0;
    int errors = 0;

    seq_div32 #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done),
        .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero),
        .as_a(as_a), .as_b(as_b), .as_c0(as_c0), .as_s(as_s)
    );

    // Shared add/sub unit model
    assign as_s = as_c0 ? ({1'b0, as_a} - {1'b0, as_b}) : ({1'b0, as_a} + {1'b0, as_b});

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Handshake invariants, checked every cycle outside reset
    always @(negedge clk) begin
        if (rst_n) begin
            chk("c0_only_busy", 64'(as_c0), 64'(busy));
            chk("done_busy_overlap", 64'(done & busy), 64'd0);
        end
    end

    // Call at a negedge; returns at the negedge after the accepting edge.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(negedge clk);
        start    = 1'b0;
    endtask

    // Returns at the negedge where done is high (or after the timeout).
    task automatic wait_done(input string tag, input int exp_busy,
                             input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz);
        int  nbusy = 0;
        bit  seen = 0;
        for (int i = 0; i < 100; i++) begin
            if (done) begin
                seen = 1;
                break;
            end
            if (busy) nbusy++;
            @(negedge clk);
        end
        chk({tag, "_done_seen"}, 64'(seen), 64'd1);
        if (exp_busy >= 0) chk({tag, "_busy_cycles"}, 64'(nbusy), 64'(exp_busy));
        chk({tag, "_quotient"}, 64'(quotient), 64'(eq));
        chk({tag, "_remainder"}, 64'(remainder), 64'(er));
        chk({tag, "_dbz"}, 64'(div_by_zero), 64'(edz));
    endtask

    task automatic do_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz);
        @(negedge clk);
        launch(a, b);
        wait_done(tag, W, eq, er, edz);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] a, b;
        int nd;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_quotient", 64'(quotient), 64'd0);
        chk("rst_remainder", 64'(remainder), 64'd0);
        chk("rst_dbz", 64'(div_by_zero), 64'd0);
        chk("rst_as_c0", 64'(as_c0), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", 64'(busy), 64'd0);

        // T1
        do_div("t1", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        @(negedge clk);
        chk("t1_done_one_cycle", 64'(done), 64'd0);
        chk("t1_hold_q", 64'(quotient), 64'd14);

        // T2 and large-operand edges
        do_div("t2a", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0);
        do_div("t2b", 32'h8000_0000, 32'd3, 32'h2AAA_AAAA, 32'd2, 1'b0);
        do_div("t2c", 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFE, 1'b0);
        do_div("t2d", 32'hFFFF_FFFF, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0);
        do_div("t2e", 32'd0, 32'd9, 32'd0, 32'd0, 1'b0);

        // T3: divide by zero, then back-to-back start during DONE
        do_div("t3a", 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1);
        launch(32'd9, 32'd3);
        chk("t3_b2b_busy", 64'(busy), 64'd1);
        repeat (5) @(negedge clk);
        chk("t3_hold_q", 64'(quotient), 64'hFFFF_FFFF);
        chk("t3_hold_dbz", 64'(div_by_zero), 64'd1);
        wait_done("t3b", W - 5, 32'd3, 32'd0, 1'b0);

        // T4: start re-pulsed at RUN cycle 10 is ignored
        @(negedge clk);
        launch(32'd50, 32'd5);
        repeat (9) @(negedge clk);
        start = 1'b1; dividend = 32'd77; divisor = 32'd7;
        @(negedge clk);
        start = 1'b0;
        wait_done("t4", W - 10, 32'd10, 32'd0, 1'b0);

        // T5: reset mid-run abandons the division
        @(negedge clk);
        launch(32'd1000, 32'd3);
        repeat (15) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t5_busy", 64'(busy), 64'd0);
        chk("t5_done", 64'(done), 64'd0);
        chk("t5_quotient", 64'(quotient), 64'd0);
        chk("t5_remainder", 64'(remainder), 64'd0);
        chk("t5_as_c0", 64'(as_c0), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) nd++;
        end
        chk("t5_no_activity", 64'(nd), 64'd0);
        do_div("t5b", 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0);

        // T6: randomised pairs against the golden model
        for (int i = 0; i < 200; i++) begin
            a = $urandom;
            case (i % 6)
                0: b = $urandom;
                1: b = $urandom_range(1, 255);
                2: b = a;
                3: b = 32'd1;
                4: begin b = $urandom | 32'h8000_0000; a = a >> 1; end
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            if (b == 0) b = 32'd1;
            do_div("t6", a, b, a / b, a % b, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
